// File: rtl/nbiot_ul_pkg.sv
// Shared constants and types for the NB-IoT uplink NPUSCH format-1 slot scheduler.
package nbiot_ul_pkg;

    localparam int SAMPLE_W = 32;
    localparam int N_SC     = 12;
    localparam int N_SYMB   = 7;
    localparam int DMRS_SYM = 3;

    localparam logic [SAMPLE_W-1:0] FP_P0707 = 32'h3F34FDF4;
    localparam logic [SAMPLE_W-1:0] FP_N0707 = 32'hBF34FDF4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbiot_grid_counter.sv
// Subcarrier / symbol / slot position counters for one transmission, with a
// flag marking the final grid position of the run.
module nbiot_grid_counter
    import nbiot_ul_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] num_slots,
    output logic [3:0] sc,
    output logic [2:0] sym,
    output logic [7:0] slot,
    output logic       last
);

    localparam logic [3:0] SC_MAX  = 4'(N_SC - 1);
    localparam logic [2:0] SYM_MAX = 3'(N_SYMB - 1);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            sc   <= '0;
            sym  <= '0;
            slot <= '0;
        end else if (advance) begin
            if (sc == SC_MAX) begin
                sc <= '0;
                if (sym == SYM_MAX) begin
                    sym  <= '0;
                    slot <= slot + 8'd1;
                end else begin
                    sym <= sym + 3'd1;
                end
            end else begin
                sc <= sc + 4'd1;
            end
        end
    end

    assign last = (sc == SC_MAX) && (sym == SYM_MAX) && (slot == num_slots - 8'd1);

endmodule

// File: rtl/nbiot_ul_slot_scheduler.sv
// Interleaves DMRS and data samples into SC-FDMA grid order for one NPUSCH
// format-1 transmission, with a single registered output stage.
module nbiot_ul_slot_scheduler
    import nbiot_ul_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          num_slots,
    output logic                busy,
    output logic                done,
    input  logic                dmrs_valid,
    output logic                dmrs_ready,
    input  logic [SAMPLE_W-1:0] dmrs_data,
    input  logic                dat_valid,
    output logic                dat_ready,
    input  logic [SAMPLE_W-1:0] dat_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic [3:0]          out_sc,
    output logic [2:0]          out_sym,
    output logic [7:0]          out_slot,
    output logic                out_is_dmrs
);

    state_t     state;
    logic [7:0] slots_lat;
    logic       last_taken;
    logic [3:0] sc;
    logic [2:0] sym;
    logic [7:0] slot;
    logic       last;
    logic       sel_dmrs;
    logic       can_take;
    logic       take;
    logic       clear;

    nbiot_grid_counter u_grid (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .advance   (take),
        .num_slots (slots_lat),
        .sc        (sc),
        .sym       (sym),
        .slot      (slot),
        .last      (last)
    );

    // The only combinational path: readies follow out_ready so a drained
    // output register can be refilled in the same cycle.
    assign sel_dmrs   = (sym == 3'(DMRS_SYM));
    assign can_take   = (state == RUN) && !last_taken && (!out_valid || out_ready);
    assign dmrs_ready = can_take && sel_dmrs;
    assign dat_ready  = can_take && !sel_dmrs;
    assign take       = sel_dmrs ? (dmrs_valid && dmrs_ready) : (dat_valid && dat_ready);
    assign clear      = (state == IDLE) && start;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            slots_lat   <= '0;
            last_taken  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sc      <= '0;
            out_sym     <= '0;
            out_slot    <= '0;
            out_is_dmrs <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        slots_lat  <= num_slots;
                        last_taken <= 1'b0;
                        state      <= (num_slots == 8'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        out_valid   <= 1'b1;
                        out_data    <= sel_dmrs ? dmrs_data : dat_data;
                        out_sc      <= sc;
                        out_sym     <= sym;
                        out_slot    <= slot;
                        out_is_dmrs <= sel_dmrs;
                        if (last) last_taken <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (last_taken) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nbiot_ul_slot_scheduler.sv
// Randomised directed bench for nbiot_ul_slot_scheduler against an arithmetic grid-order model.
module tb_nbiot_ul_slot_scheduler;
    import nbiot_ul_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [7:0]          num_slots;
    logic                busy, done;
    logic                dmrs_valid, dmrs_ready;
    logic [SAMPLE_W-1:0] dmrs_data;
    logic                dat_valid, dat_ready;
    logic [SAMPLE_W-1:0] dat_data;
    logic                out_valid, out_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic [3:0]          out_sc;
    logic [2:0]          out_sym;
    logic [7:0]          out_slot;
    logic                out_is_dmrs;

    nbiot_ul_slot_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .num_slots(num_slots),
        .busy(busy), .done(done),
        .dmrs_valid(dmrs_valid), .dmrs_ready(dmrs_ready), .dmrs_data(dmrs_data),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sc(out_sc), .out_sym(out_sym), .out_slot(out_slot), .out_is_dmrs(out_is_dmrs)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_out, n_dmrs, dmrs_idx, dat_idx;
    int last_fire, first_fire, done_cyc;
    int v_prob, r_prob;
    bit alt_mode, done_seen, any_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dmrs_word(input int i, input bit alt);
        if (alt) return (i % 2 == 0) ? FP_P0707 : FP_N0707;
        return 32'hD000_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] data_word(input int i);
        return 32'd1 + 32'(i);
    endfunction

    // k-th output of a run: grid position from k, and which ordinal of each source lands there.
    function automatic logic [47:0] exp_out(input int k, input bit alt);
        int slot, r, sym, sc, i;
        logic [31:0] w;
        slot = k / (N_SC * N_SYMB);
        r    = k % (N_SC * N_SYMB);
        sym  = r / N_SC;
        sc   = r % N_SC;
        if (sym == DMRS_SYM) begin
            i = slot * N_SC + sc;
            w = dmrs_word(i, alt);
        end else begin
            i = slot * (N_SYMB - 1) * N_SC + ((sym < DMRS_SYM) ? sym : sym - 1) * N_SC + sc;
            w = data_word(i);
        end
        return {w, 4'(sc), 3'(sym), 8'(slot), (sym == DMRS_SYM)};
    endfunction

    task automatic drive_sources();
        dmrs_valid = ($urandom_range(0, 99) < v_prob);
        dat_valid  = ($urandom_range(0, 99) < v_prob);
        out_ready  = ($urandom_range(0, 99) < r_prob);
        dmrs_data  = dmrs_word(dmrs_idx, alt_mode);
        dat_data   = data_word(dat_idx);
    endtask

    task automatic step();
        logic dfire, tfire, ofire;
        logic [47:0] obs;
        #3;
        dfire = dmrs_valid && dmrs_ready;
        tfire = dat_valid && dat_ready;
        ofire = out_valid && out_ready;
        obs   = {out_data, out_sc, out_sym, out_slot, out_is_dmrs};
        if (dmrs_ready || dat_ready) any_ready = 1'b1;
        if (out_valid && !out_ready)
            chk("ready_under_backpressure", {62'd0, dmrs_ready, dat_ready}, 64'd0);
        if (ofire) begin
            chk($sformatf("output_%0d", n_out), {16'd0, obs}, {16'd0, exp_out(n_out, alt_mode)});
            if (out_is_dmrs) n_dmrs++;
            if (first_fire < 0) first_fire = cyc;
            n_out++;
            last_fire = cyc;
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (dfire) dmrs_idx++;
        if (tfire) dat_idx++;
        drive_sources();
    endtask

    task automatic run_tx(input int ns, input int vp, input int rp, input bit alt,
                          input int abort_at, input bit perturb);
        int start_cyc, budget;
        n_out = 0; n_dmrs = 0; dmrs_idx = 0; dat_idx = 0;
        done_seen = 1'b0; any_ready = 1'b0; first_fire = -1; done_cyc = -1;
        v_prob = vp; r_prob = rp; alt_mode = alt;
        drive_sources();
        num_slots = 8'(ns);
        start     = 1'b1;
        start_cyc = cyc;
        last_fire = cyc;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(ns != 0));
        budget = 0;
        while (!done_seen && budget < 6000) begin
            if (abort_at > 0 && n_out == abort_at) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
                chk("reset_midrun_outputs",
                    {6'd0, out_valid, out_data, out_sc, out_sym, out_slot, out_is_dmrs,
                     busy, done, dmrs_ready, dat_ready}, 64'd0);
                reset = 1'b1;
                return;
            end
            if (perturb && cyc == start_cyc + 50) begin
                start     = 1'b1;
                num_slots = 8'($urandom_range(1, 255));
            end else if (perturb && cyc == start_cyc + 51) begin
                start = 1'b0;
            end
            step();
            budget++;
        end
        chk("done_seen", 64'(done_seen), 64'd1);
        chk("out_count", 64'(n_out), 64'(ns * N_SC * N_SYMB));
        chk("dmrs_count", 64'(n_dmrs), 64'(ns * N_SC));
        chk("done_after_last_output", 64'(done_cyc), 64'(last_fire + 1));
        if (vp == 100 && rp == 100) begin
            chk("done_cycle", 64'(done_cyc),
                64'(start_cyc + ((ns == 0) ? 1 : ns * N_SC * N_SYMB + 2)));
            if (ns > 0) chk("first_output_cycle", 64'(first_fire), 64'(start_cyc + 2));
        end
        if (ns == 0) chk("no_ready_zero_slots", 64'(any_ready), 64'd0);
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_back_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_slots = 8'd0;
        v_prob = 0; r_prob = 0; alt_mode = 1'b0; dmrs_idx = 0; dat_idx = 0;
        drive_sources();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            {6'd0, out_valid, out_data, out_sc, out_sym, out_slot, out_is_dmrs,
             busy, done, dmrs_ready, dat_ready}, 64'd0);
        reset = 1'b1;
        step();

        run_tx(1, 100, 100, 1'b0, 0, 1'b0);
        run_tx(2, 100, 100, 1'b1, 0, 1'b0);
        run_tx(2, 60, 50, 1'b0, 0, 1'b0);
        run_tx(3, 50, 50, 1'b1, 0, 1'b0);
        run_tx(0, 100, 100, 1'b0, 0, 1'b0);
        run_tx(2, 100, 100, 1'b0, 40, 1'b0);
        run_tx(1, 100, 100, 1'b0, 0, 1'b0);
        run_tx(2, 100, 100, 1'b0, 0, 1'b1);
        run_tx(2, 70, 60, 1'b1, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
